// File: rtl/gt_rx_word_aligner_pkg.sv
// Shared GT/PHY definitions for the RX word aligner: comma value, lock states, lane type.
package gt_rx_word_aligner_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef logic [1:0] lane_t;

  // Lane index of a hit vector; only meaningful when exactly one bit is set.
  function automatic lane_t lane_of(input logic [3:0] hit);
    lane_t l;
    l = '0;
    for (int k = 0; k < 4; k++) begin
      if (hit[k]) l = lane_t'(k);
    end
    return l;
  endfunction

endpackage

// File: rtl/gt_byte_rotator.sv
// Combinational 4-way byte/K-flag rotator: picks 4 consecutive bytes from {cur, prev}.
module gt_byte_rotator
  import gt_rx_word_aligner_pkg::*;
(
  input  logic [31:0] prev_data_i,
  input  logic [3:0]  prev_char_i,
  input  logic [31:0] cur_data_i,
  input  logic [3:0]  cur_char_i,
  input  lane_t       offset_i,
  output logic [31:0] data_o,
  output logic [3:0]  char_o
);

  logic [63:0] pair_data;
  logic [7:0]  pair_char;

  // Byte stream in arrival order: prev bytes 0..3, then cur bytes 0..3.
  assign pair_data = {cur_data_i, prev_data_i};
  assign pair_char = {cur_char_i, prev_char_i};

  assign data_o = pair_data[{1'b0, offset_i, 3'b000} +: 32];
  assign char_o = pair_char[{1'b0, offset_i} +: 4];

endmodule

// File: rtl/gt_rx_word_aligner.sv
// GT RX word aligner: finds the K28.5 lane, rotates it into byte 0, tracks lock and loss.
module gt_rx_word_aligner
  import gt_rx_word_aligner_pkg::*;
#(
  parameter logic [7:0] COMMA_BYTE  = K28_5,
  parameter int         LOCK_CNT    = 4,
  parameter int         UNLOCK_CNT  = 4,
  parameter int         WDOG_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_done,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_char,
  output logic [31:0] o_data,
  output logic [3:0]  o_char,
  output logic        o_valid,
  output logic        o_locked,
  output logic [1:0]  o_offset,
  output logic        o_realign,
  output logic [15:0] o_loss_cnt
);

  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

  lock_state_e     state_q, state_d;
  lane_t           offset_q, offset_d;
  logic [3:0]      good_q, good_d, bad_q, bad_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic [31:0]     d1_data_q, data_q, aligned_data;
  logic [3:0]      d1_char_q, char_q, aligned_char;
  logic [3:0]      hit;
  logic            single, at_off, loss;
  logic            valid_q, realign_q;
  logic [15:0]     loss_cnt_q;
  lane_t           hit_lane;

  // Comma detection is suppressed while the transceiver is not ready.
  always_comb begin
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      hit[k] = i_rx_done & i_rx_char[k] & (i_rx_data[8*k +: 8] == COMMA_BYTE);
    end
  end

  assign single   = $onehot(hit);
  assign hit_lane = lane_of(hit);
  assign at_off   = (hit == (4'b0001 << offset_q));

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    good_d   = good_q;
    bad_d    = bad_q;
    wdog_d   = wdog_q;
    loss     = 1'b0;
    if (!i_rx_done) begin
      state_d = UNLOCKED;
      good_d  = '0;
      bad_d   = '0;
      wdog_d  = '0;
      loss    = (state_q == LOCKED);
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (single) begin
            offset_d = hit_lane;
            good_d   = 4'd1;
            state_d  = CHECK;
          end
        end
        CHECK: begin
          if (single) begin
            if (hit_lane == offset_q) begin
              good_d = good_q + 4'd1;
              if (good_d == 4'(LOCK_CNT)) begin
                state_d = LOCKED;
                bad_d   = '0;
                wdog_d  = '0;
              end
            end else begin
              offset_d = hit_lane;
              good_d   = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (at_off) begin
            bad_d  = '0;
            wdog_d = '0;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
            if (|hit) bad_d = bad_q + 4'd1;
          end
          if (bad_d == 4'(UNLOCK_CNT) || wdog_d == WD_W'(WDOG_CYCLES - 1)) begin
            state_d = UNLOCKED;
            good_d  = '0;
            bad_d   = '0;
            wdog_d  = '0;
            loss    = 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  gt_byte_rotator u_rot (
    .prev_data_i (d1_data_q),
    .prev_char_i (d1_char_q),
    .cur_data_i  (i_rx_data),
    .cur_char_i  (i_rx_char),
    .offset_i    (offset_q),
    .data_o      (aligned_data),
    .char_o      (aligned_char)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= UNLOCKED;
      offset_q   <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      wdog_q     <= '0;
      d1_data_q  <= '0;
      d1_char_q  <= '0;
      data_q     <= '0;
      char_q     <= '0;
      valid_q    <= 1'b0;
      realign_q  <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      wdog_q    <= wdog_d;
      d1_data_q <= i_rx_done ? i_rx_data : '0;
      d1_char_q <= i_rx_done ? i_rx_char : '0;
      data_q    <= aligned_data;
      char_q    <= aligned_char;
      valid_q   <= (state_q == LOCKED);
      realign_q <= loss;
      if (loss && loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 16'd1;
    end
  end

  assign o_data     = data_q;
  assign o_char     = char_q;
  assign o_valid    = valid_q;
  assign o_locked   = (state_q == LOCKED);
  assign o_offset   = offset_q;
  assign o_realign  = realign_q;
  assign o_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_gt_rx_word_aligner.sv
// Randomized bench for gt_rx_word_aligner against a byte-stream / lock-rule reference model.
module tb_gt_rx_word_aligner;

  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_CNT  = 4;
  localparam int WDOG_CYCLES = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [31:0] rx_data;
  logic [3:0]  rx_char;
  logic [31:0] o_data;
  logic [3:0]  o_char;
  logic        o_valid, o_locked, o_realign;
  logic [1:0]  o_offset;
  logic [15:0] o_loss_cnt;

  gt_rx_word_aligner #(
    .COMMA_BYTE (8'hBC),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx_done (rx_done),
    .i_rx_data (rx_data),
    .i_rx_char (rx_char),
    .o_data    (o_data),
    .o_char    (o_char),
    .o_valid   (o_valid),
    .o_locked  (o_locked),
    .o_offset  (o_offset),
    .o_realign (o_realign),
    .o_loss_cnt(o_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected output registers after each clock edge.
  int          m_off, m_run, m_bad, m_wd, m_loss;
  bit          m_locked, m_valid, m_realign;
  logic [31:0] m_prev_d, m_data;
  logic [3:0]  m_prev_c, m_char;

  task automatic m_reset();
    m_off = 0; m_run = 0; m_bad = 0; m_wd = 0; m_loss = 0;
    m_locked = 0; m_valid = 0; m_realign = 0;
    m_prev_d = '0; m_prev_c = '0; m_data = '0; m_char = '0;
  endtask

  task automatic m_step(input logic [31:0] d, input logic [3:0] c, input logic done);
    logic [7:0] b [8];
    logic       kf [8];
    int         nh, lane;
    bit         loss;
    // Output = 4 bytes of the arrival-ordered stream starting at the current offset.
    for (int j = 0; j < 4; j++) begin
      b[j] = m_prev_d[8*j +: 8]; b[j+4] = d[8*j +: 8];
      kf[j] = m_prev_c[j];       kf[j+4] = c[j];
    end
    for (int j = 0; j < 4; j++) begin
      m_data[8*j +: 8] = b[m_off + j];
      m_char[j]        = kf[m_off + j];
    end
    m_valid = m_locked;
    nh = 0; lane = 0; loss = 0;
    for (int j = 0; j < 4; j++) begin
      if (done && c[j] && d[8*j +: 8] == 8'hBC) begin nh++; lane = j; end
    end
    if (!done) begin
      loss = m_locked;
      m_locked = 0; m_run = 0; m_bad = 0; m_wd = 0;
    end else if (!m_locked) begin
      if (nh == 1) begin
        if (m_run > 0 && lane == m_off) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_locked = 1; m_run = 0; m_bad = 0; m_wd = 0;
          end
        end else begin
          m_off = lane; m_run = 1;
        end
      end
    end else begin
      if (nh == 1 && lane == m_off) begin
        m_bad = 0; m_wd = 0;
      end else begin
        m_wd++;
        if (nh > 0) m_bad++;
      end
      if (m_bad == UNLOCK_CNT || m_wd == WDOG_CYCLES - 1) begin
        loss = 1; m_locked = 0; m_run = 0; m_bad = 0; m_wd = 0;
      end
    end
    m_realign = loss;
    if (loss && m_loss < 65535) m_loss++;
    m_prev_d = done ? d : '0;
    m_prev_c = done ? c : '0;
  endtask

  task automatic compare_all();
    chk("o_data",     o_data,             m_data);
    chk("o_char",     32'(o_char),        32'(m_char));
    chk("o_valid",    32'(o_valid),       32'(m_valid));
    chk("o_locked",   32'(o_locked),      32'(m_locked));
    chk("o_offset",   32'(o_offset),      32'(m_off));
    chk("o_realign",  32'(o_realign),     32'(m_realign));
    chk("o_loss_cnt", 32'(o_loss_cnt),    32'(m_loss));
  endtask

  // Called at a negedge: drive, clock, update model, compare at the next negedge.
  task automatic cycle(input logic [31:0] d, input logic [3:0] c, input logic done);
    rx_data = d; rx_char = c; rx_done = done;
    @(posedge clk);
    m_step(d, c, done);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input int lane);
    logic [31:0] d;
    logic [3:0]  c;
    d = $urandom;
    c = '0;
    if (lane >= 0) begin
      d[8*lane +: 8] = 8'hBC;
      c[lane] = 1'b1;
    end
    cycle(d, c, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(-1);
  endtask

  initial begin
    int n, stick, r;
    logic [31:0] d;
    logic [3:0]  c;
    rst_n = 1'b0; rx_done = 1'b1; rx_data = '0; rx_char = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_data",   o_data,        32'd0);
    chk("rst_loss",   32'(o_loss_cnt), 32'd0);
    rst_n = 1'b1;

    // Aligned stream, comma in lane 0 every 8th word.
    for (int i = 0; i < 5; i++) begin send(0); idle(7); end
    chk("aligned_lock", 32'(o_locked), 32'd1);

    // Three wrong-lane commas then a good one: lock holds.
    for (int i = 0; i < 3; i++) begin send(2); idle(3); end
    send(0);
    chk("wrong3_hold", 32'(o_locked), 32'd1);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      send(2);
      if (i < 3) idle(3);
    end
    chk("wrong4_unlock",  32'(o_locked),   32'd0);
    chk("wrong4_realign", 32'(o_realign),  32'd1);
    chk("wrong4_loss",    32'(o_loss_cnt), 32'd1);
    idle(3);
    for (int i = 0; i < 4; i++) begin send(2); idle(3); end
    chk("relock2",   32'(o_locked), 32'd1);
    chk("relock2_o", 32'(o_offset), 32'd2);

    // Rotated-by-2 stream: each comma must surface in byte 0 two cycles later.
    for (int i = 0; i < 6; i++) begin
      send(2); idle(1);
      chk("rot2_bc", 32'(o_data[7:0]), 32'hBC);
      chk("rot2_k",  32'(o_char[0]),   32'd1);
      idle(2);
    end

    // Transceiver not ready for 3 cycles while locked.
    cycle($urandom, 4'h0, 1'b0);
    chk("rxdone_unlock",  32'(o_locked),  32'd0);
    chk("rxdone_realign", 32'(o_realign), 32'd1);
    cycle($urandom, 4'h0, 1'b0);
    cycle($urandom, 4'h0, 1'b0);
    chk("rxdone_loss", 32'(o_loss_cnt), 32'd2);

    // Offset jump while checking.
    idle(2); send(1); idle(2); send(1); idle(2);
    for (int i = 0; i < 3; i++) begin send(3); idle(1); end
    chk("jump_notyet", 32'(o_locked), 32'd0);
    send(3);
    chk("jump_lock", 32'(o_locked), 32'd1);
    chk("jump_off",  32'(o_offset), 32'd3);

    // Watchdog: distance from the comma-bearing input cycle to the first unlocked cycle.
    idle(3); send(3);
    n = 0;
    while (o_locked && n < 2 * WDOG_CYCLES) begin send(-1); n++; end
    chk("wdog_len",  32'(n + 1),       32'(WDOG_CYCLES));
    chk("wdog_loss", 32'(o_loss_cnt),  32'd3);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin send(1); idle(2); end
    chk("pre_rst_lock", 32'(o_locked), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked",  32'(o_locked),   32'd0);
    chk("arst_valid",   32'(o_valid),    32'd0);
    chk("arst_data",    o_data,          32'd0);
    chk("arst_char",    32'(o_char),     32'd0);
    chk("arst_offset",  32'(o_offset),   32'd0);
    chk("arst_realign", 32'(o_realign),  32'd0);
    chk("arst_loss",    32'(o_loss_cnt), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: a mostly-stable comma lane with jumps, multi-hits and rx_done drops.
    stick = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cycle($urandom, 4'($urandom), 1'b0);
      end else begin
        r = $urandom_range(0, 9);
        if ($urandom_range(0, 39) == 0) stick = $urandom_range(0, 3);
        if (r < 3) begin
          send(($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : stick);
        end else if (r == 3) begin
          d = $urandom;
          c = 4'($urandom);
          for (int j = 0; j < 4; j++) if (c[j] && $urandom_range(0, 1) == 1) d[8*j +: 8] = 8'hBC;
          cycle(d, c, 1'b1);
        end else begin
          send(-1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
